// File: rtl/xm_lsu.sv
// X-Makina load/store unit: addressing-mode arithmetic, byte-lane steering and
// a req/ack memory handshake. Define XM_LSU_TIMEOUT_EN to bound the ack wait.
module xm_lsu #(
  parameter int WORD    = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              start_i,
  input  logic              we_i,
  input  logic              byteOp_i,
  input  logic [1:0]        mode_i,
  input  logic [WORD-1:0]   base_i,
  input  logic [WORD-1:0]   offs_i,
  input  logic [WORD-1:0]   data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o,
  output logic [WORD-1:0]   data_o,
  output logic              wbEn_o,
  output logic [WORD-1:0]   wbAddr_o,
  output logic              memReq_o,
  output logic              memWe_o,
  output logic [WORD-1:0]   memAdr_o,
  output logic [WORD/8-1:0] memBe_o,
  output logic [WORD-1:0]   memDat_o,
  input  logic [WORD-1:0]   memDat_i,
  input  logic              memAck_i
);

  localparam int NB = WORD / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_MIS = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;

  if ((WORD % 8) != 0 || NB < 2 || (NB & (NB - 1)) != 0 || TIMEOUT < 1) begin : g_param_err
    $error("xm_lsu: WORD must give a power-of-two lane count >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        err_q, err_d;
  logic [WORD-1:0]   adr_q, adr_d;
  logic [NB-1:0]     be_q, be_d;
  logic [WORD-1:0]   wdat_q, wdat_d;
  logic [WORD-1:0]   rdat_q, rdat_d;
  logic [WORD-1:0]   wb_q, wb_d;

  logic [WORD-1:0]   sz;
  logic [WORD-1:0]   ea;
  logic [WORD-1:0]   wb_val;
  logic              misal;
  logic              tmo_hit;

  function automatic logic [NB-1:0] lane_mask(input logic is_byte, input logic [LW-1:0] lane);
    logic [NB-1:0] m;
    m = is_byte ? (NB'(1) << lane) : '1;
    return m;
  endfunction

  function automatic logic [WORD-1:0] lane_replicate(input logic is_byte, input logic [WORD-1:0] d);
    logic [WORD-1:0] r;
    r = is_byte ? {NB{d[7:0]}} : d;
    return r;
  endfunction

  function automatic logic [WORD-1:0] lane_extract(input logic is_byte, input logic [LW-1:0] lane,
                                                   input logic [WORD-1:0] d);
    logic [WORD-1:0] sh;
    sh = d >> {lane, 3'b000};
    return is_byte ? {{(WORD-8){1'b0}}, sh[7:0]} : d;
  endfunction

  // Addressing-mode arithmetic on the live command inputs, wrapping mod 2^WORD.
  always_comb begin
    sz     = byteOp_i ? WORD'(1) : WORD'(NB);
    ea     = base_i;
    wb_val = base_i;
    case (mode_i)
      2'd1:    wb_val = base_i + sz;
      2'd2:    begin
        ea     = base_i - sz;
        wb_val = base_i - sz;
      end
      2'd3:    ea = base_i + offs_i;
      default: ;
    endcase
    misal = !byteOp_i && (ea[LW-1:0] != '0);
  end

`ifdef XM_LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (state_q == S_REQ && !memAck_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count reaches TIMEOUT on this un-acked cycle.
  assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    byte_d  = byte_q;
    mode_d  = mode_q;
    err_d   = err_q;
    adr_d   = adr_q;
    be_d    = be_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    wb_d    = wb_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          we_d   = we_i;
          byte_d = byteOp_i;
          mode_d = mode_i;
          adr_d  = ea;
          be_d   = lane_mask(byteOp_i, ea[LW-1:0]);
          wdat_d = lane_replicate(byteOp_i, data_i);
          wb_d   = wb_val;
          if (misal) begin
            err_d   = ERR_MIS;
            state_d = S_DONE;
          end else begin
            err_d   = ERR_OK;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (memAck_i) begin
          if (!we_q) begin
            rdat_d = lane_extract(byte_q, adr_q[LW-1:0], memDat_i);
          end
          state_d = S_DONE;
        end else if (tmo_hit) begin
          err_d   = ERR_TMO;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      mode_q  <= 2'd0;
      err_q   <= ERR_OK;
      adr_q   <= '0;
      be_q    <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
      be_q    <= be_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      wb_q    <= wb_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign err_o    = done_o ? err_q : ERR_OK;
  assign wbEn_o   = done_o && (err_q == ERR_OK) && (mode_q == 2'd1 || mode_q == 2'd2);
  assign wbAddr_o = wb_q;
  assign data_o   = rdat_q;
  assign memReq_o = (state_q == S_REQ);
  assign memWe_o  = (state_q == S_REQ) && we_q;
  assign memAdr_o = adr_q;
  assign memBe_o  = be_q;
  assign memDat_o = wdat_q;

endmodule

// File: tb/tb_xm_lsu.sv
// Scoreboard bench for xm_lsu (WORD=16, TIMEOUT=4); exercises the timeout path
// only when XM_LSU_TIMEOUT_EN is defined.
module tb_xm_lsu;

  logic        clk = 1'b0;
  logic        arst_i, start_i, we_i, byteOp_i;
  logic [1:0]  mode_i;
  logic [15:0] base_i, offs_i, data_i;
  logic        busy_o, done_o, wbEn_o, memReq_o, memWe_o, memAck_i;
  logic [1:0]  err_o, memBe_o;
  logic [15:0] data_o, wbAddr_o, memAdr_o, memDat_o, memDat_i;

  typedef struct packed {
    logic [1:0]  err;
    logic [15:0] data;
    logic        wben;
    logic [15:0] wb;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_data = 16'h0000;
  int          n_chk = 0;
  int          n_bad = 0;

  xm_lsu #(.WORD(16), .TIMEOUT(4)) dut (
    .clk_i(clk), .arst_i(arst_i), .start_i(start_i), .we_i(we_i), .byteOp_i(byteOp_i),
    .mode_i(mode_i), .base_i(base_i), .offs_i(offs_i), .data_i(data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .data_o(data_o),
    .wbEn_o(wbEn_o), .wbAddr_o(wbAddr_o), .memReq_o(memReq_o), .memWe_o(memWe_o),
    .memAdr_o(memAdr_o), .memBe_o(memBe_o), .memDat_o(memDat_o),
    .memDat_i(memDat_i), .memAck_i(memAck_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Completion monitor: every done_o pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", done_o, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("err", err_o, e.err);
        check("wben", wbEn_o, e.wben);
        check("data", data_o, e.data);
        if (e.wben) check("wbaddr", wbAddr_o, e.wb);
      end
    end
  end

  task automatic scramble();
    we_i     = 1'($urandom);
    byteOp_i = 1'($urandom);
    mode_i   = 2'($urandom);
    base_i   = 16'($urandom);
    offs_i   = 16'($urandom);
    data_i   = 16'($urandom);
  endtask

  task automatic run_cmd(input logic we, input logic bop, input logic [1:0] mode,
                         input logic [15:0] base, input logic [15:0] offs,
                         input logic [15:0] data, input int waits, input logic [15:0] rdat);
    logic [15:0] sz, ea, wb, wdat, ld;
    logic [1:0]  be;
    logic        lane, mis;
    exp_t        e;
    sz = bop ? 16'd1 : 16'd2;
    case (mode)
      2'd0:    begin ea = base;        wb = base;      end
      2'd1:    begin ea = base;        wb = base + sz; end
      2'd2:    begin ea = base - sz;   wb = ea;        end
      default: begin ea = base + offs; wb = base;      end
    endcase
    lane = ea[0];
    mis  = !bop && lane;
    be   = bop ? (lane ? 2'b10 : 2'b01) : 2'b11;
    wdat = bop ? {data[7:0], data[7:0]} : data;
    ld   = bop ? (lane ? {8'h00, rdat[15:8]} : {8'h00, rdat[7:0]}) : rdat;
    if (!we && !mis) exp_data = ld;
    e.err  = mis ? 2'd1 : 2'd0;
    e.data = exp_data;
    e.wben = (mode == 2'd1 || mode == 2'd2) && !mis;
    e.wb   = wb;
    exp_q.push_back(e);

    @(negedge clk);
    start_i = 1'b1; we_i = we; byteOp_i = bop; mode_i = mode;
    base_i = base; offs_i = offs; data_i = data;
    @(negedge clk);
    start_i = 1'b0;
    scramble();
    if (mis) begin
      check("mis_req", memReq_o, 1'b0);
      check("mis_done", done_o, 1'b1);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("ign_busy", busy_o, 1'b0);
      check("ign_req", memReq_o, 1'b0);
      return;
    end
    check("req", memReq_o, 1'b1);
    check("memwe", memWe_o, we);
    check("adr", memAdr_o, ea);
    check("be", memBe_o, be);
    if (we) check("wdat", memDat_o, wdat);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      scramble();
      start_i = 1'b1;
      check("hold_req", memReq_o, 1'b1);
      check("hold_adr", memAdr_o, ea);
    end
    start_i  = 1'b0;
    memAck_i = 1'b1;
    memDat_i = rdat;
    @(negedge clk);
    memAck_i = 1'b0;
    memDat_i = 16'($urandom);
    check("ack_req", memReq_o, 1'b0);
    check("lat_done", done_o, 1'b1);
    @(negedge clk);
    check("idle", busy_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    arst_i = 1'b1; start_i = 1'b0; memAck_i = 1'b0; memDat_i = 16'h0;
    we_i = 1'b0; byteOp_i = 1'b0; mode_i = 2'd0;
    base_i = 16'h0; offs_i = 16'h0; data_i = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_req", memReq_o, 1'b0);
    check("rst_data", data_o, 16'h0);
    check("rst_wben", wbEn_o, 1'b0);
    check("rst_be", memBe_o, 2'b00);
    arst_i = 1'b0;
    @(negedge clk);

    run_cmd(1'b0, 1'b0, 2'd0, 16'h1000, 16'h0000, 16'h0000, 0, 16'hBEEF);
    run_cmd(1'b1, 1'b1, 2'd1, 16'h2001, 16'h0000, 16'h12AB, 3, 16'h0000);
    run_cmd(1'b0, 1'b0, 2'd2, 16'h0000, 16'h0000, 16'h0000, 1, 16'h1234);
    run_cmd(1'b0, 1'b1, 2'd0, 16'h3001, 16'h0000, 16'h0000, 2, 16'h5A00);
    run_cmd(1'b0, 1'b1, 2'd3, 16'h4000, 16'h0010, 16'h0000, 0, 16'h5A77);
    run_cmd(1'b0, 1'b0, 2'd1, 16'h0003, 16'h0000, 16'h0000, 0, 16'h0000);
    run_cmd(1'b1, 1'b1, 2'd2, 16'h0000, 16'h0000, 16'h00C3, 1, 16'h0000);
    run_cmd(1'b1, 1'b0, 2'd3, 16'hFFF0, 16'h0020, 16'hCAFE, 0, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      run_cmd(1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), $urandom_range(0, 3), 16'($urandom));
    end

`ifdef XM_LSU_TIMEOUT_EN
    begin
      exp_t e;
      int   n;
      e.err = 2'd2; e.data = exp_data; e.wben = 1'b0; e.wb = 16'h0;
      exp_q.push_back(e);
      @(negedge clk);
      start_i = 1'b1; we_i = 1'b0; byteOp_i = 1'b0; mode_i = 2'd1;
      base_i = 16'h6000; offs_i = 16'h0; data_i = 16'h0;
      @(negedge clk);
      start_i = 1'b0;
      n = 1;
      while (!done_o && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("tmo_cycle", n, 5);
      check("tmo_req", memReq_o, 1'b0);
      @(negedge clk);
    end
`endif

    @(negedge clk);
    start_i = 1'b1; we_i = 1'b0; byteOp_i = 1'b0; mode_i = 2'd1;
    base_i = 16'h5000; offs_i = 16'h0; data_i = 16'h0;
    @(negedge clk);
    start_i = 1'b0;
`ifdef XM_LSU_TIMEOUT_EN
    repeat (1) @(negedge clk);
`else
    repeat (20) @(negedge clk);
`endif
    check("wait_busy", busy_o, 1'b1);
    check("wait_req", memReq_o, 1'b1);
    arst_i = 1'b1;
    @(negedge clk);
    arst_i = 1'b0;
    check("mrst_req", memReq_o, 1'b0);
    check("mrst_done", done_o, 1'b0);
    check("mrst_busy", busy_o, 1'b0);
    check("mrst_wben", wbEn_o, 1'b0);
    check("mrst_data", data_o, 16'h0);
    exp_data = 16'h0000;
    @(negedge clk);
    check("mrst_quiet", done_o, 1'b0);

    run_cmd(1'b0, 1'b0, 2'd2, 16'h7004, 16'h0000, 16'h0000, 2, 16'h9876);
    repeat (2) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
